// File: rtl/spi_master.sv
// spi_master: single-byte SPI initiator.
// Takes one byte over a valid/ready handshake and runs a full-duplex SPI frame:
// the slave is selected, SCLK comes from a divider of w_Clk, the byte goes out
// on MOSI and a byte is shifted in from MISO. MODE selects CPOL/CPHA and
// FRAME_FORMAT selects MSB- or LSB-first framing. These use the same encoding
// as the SPI slave.
//
// Frame sequence: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//
// Timing, with DIV = the clamped CLK_DIV:
//   - o_ss is low for 18*DIV cycles.
//   - o_rx_valid pulses one cycle after o_ss rises, so it arrives
//     1 + 18*DIV cycles after the handshake.
//   - After that pulse, GAP holds o_ss high for CS_GAP cycles before
//     o_tx_ready returns.
//   - So back-to-back frames start every 2 + 18*DIV + CS_GAP cycles.
module spi_master #(
  parameter int MODE         = 0,
  parameter int FRAME_FORMAT = 0,
  parameter int CLK_DIV      = 2,
  parameter int CS_GAP       = 2
) (
  input  logic       w_Clk,
  input  logic       i_Rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_ss
);

  // Mode decode
  localparam logic CPOL      = (MODE == 2) || (MODE == 3);
  localparam logic CPHA      = (MODE == 1) || (MODE == 3);
  localparam logic LSB_FIRST = (FRAME_FORMAT == 1);

  // Divider and gap limits. Both are clamped so they fit the 8-bit counters.
  localparam int         DIV_I     = (CLK_DIV < 2) ? 2 : ((CLK_DIV > 255) ? 255 : CLK_DIV);
  localparam int         GAP_I     = (CS_GAP < 1) ? 1 : ((CS_GAP > 255) ? 255 : CS_GAP);
  localparam logic [7:0] DIV_LAST  = 8'(DIV_I - 1);
  // HOLD runs one cycle past its DIV_I cycles of o_ss low. That extra cycle
  // separates the o_ss release from the o_rx_valid strobe.
  localparam logic [7:0] HOLD_LAST = 8'(DIV_I);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_I);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t     state_reg;
  logic [7:0] div_cnt_reg;
  logic [4:0] edge_cnt_reg;
  logic [7:0] gap_cnt_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] rx_byte_reg;
  logic       rx_valid_reg;
  logic       tx_ready_reg;
  logic       busy_reg;
  logic       sclk_reg;
  logic       mosi_reg;
  logic       ss_reg;

  // Per-edge helper terms
  logic       div_done;
  logic [4:0] edge_num;
  logic       leading_edge;
  logic       sample_now;
  logic       tx_cur_bit;
  logic       tx_nxt_bit;
  logic [7:0] tx_shifted;
  logic [7:0] rx_shifted;

  assign div_done     = (div_cnt_reg == DIV_LAST);
  // edge_num is the number of the SCLK edge about to be produced (1..16).
  assign edge_num     = edge_cnt_reg + 5'd1;
  assign leading_edge = edge_num[0];
  // CPHA=0 samples MISO on leading edges; CPHA=1 samples on trailing edges.
  assign sample_now   = leading_edge ^ CPHA;
  assign tx_cur_bit   = LSB_FIRST ? tx_shift_reg[0] : tx_shift_reg[7];
  assign tx_nxt_bit   = LSB_FIRST ? tx_shift_reg[1] : tx_shift_reg[6];
  assign tx_shifted   = LSB_FIRST ? {1'b0, tx_shift_reg[7:1]} : {tx_shift_reg[6:0], 1'b0};
  assign rx_shifted   = LSB_FIRST ? {i_miso, rx_shift_reg[7:1]} : {rx_shift_reg[6:0], i_miso};

  // Frame FSM: sequences the states and updates every registered output.
  always_ff @(posedge w_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg    <= ST_GAP;
      div_cnt_reg  <= 8'd0;
      edge_cnt_reg <= 5'd0;
      gap_cnt_reg  <= GAP_LOAD;
      tx_shift_reg <= 8'd0;
      rx_shift_reg <= 8'd0;
      rx_byte_reg  <= 8'd0;
      rx_valid_reg <= 1'b0;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      sclk_reg     <= CPOL;
      mosi_reg     <= 1'b0;
      ss_reg       <= 1'b1;
    end else begin
      rx_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ss_reg   <= 1'b1;
          sclk_reg <= CPOL;
          if (i_tx_valid && tx_ready_reg) begin
            tx_shift_reg <= i_tx_byte;
            rx_shift_reg <= 8'd0;
            mosi_reg     <= LSB_FIRST ? i_tx_byte[0] : i_tx_byte[7];
            ss_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            tx_ready_reg <= 1'b0;
            div_cnt_reg  <= 8'd0;
            edge_cnt_reg <= 5'd0;
            state_reg    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          // SCLK stays idle here so the slave sees o_ss low before the first edge.
          if (div_done) begin
            div_cnt_reg <= 8'd0;
            state_reg   <= ST_XFER;
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end

        ST_XFER: begin
          if (div_done) begin
            div_cnt_reg  <= 8'd0;
            edge_cnt_reg <= edge_num;
            sclk_reg     <= ~sclk_reg;
            if (sample_now) begin
              rx_shift_reg <= rx_shifted;
            end
            if (CPHA) begin
              // CPHA=1: each leading edge puts the next bit on MOSI.
              if (leading_edge) begin
                mosi_reg     <= tx_cur_bit;
                tx_shift_reg <= tx_shifted;
              end
            end else begin
              // CPHA=0: the first bit went out at acceptance. Trailing edges
              // 2..14 advance to the next bit; edge 16 does not.
              if (!leading_edge && (edge_num <= 5'd14)) begin
                mosi_reg     <= tx_nxt_bit;
                tx_shift_reg <= tx_shifted;
              end
            end
            if (edge_num == 5'd16) begin
              sclk_reg  <= CPOL;
              state_reg <= ST_HOLD;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end

        ST_HOLD: begin
          if (div_cnt_reg == HOLD_LAST) begin
            rx_byte_reg  <= rx_shift_reg;
            rx_valid_reg <= 1'b1;
            gap_cnt_reg  <= GAP_LOAD;
            state_reg    <= ST_GAP;
          end else begin
            if (div_done) begin
              ss_reg <= 1'b1;
            end
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg <= 8'd1) begin
            tx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready = tx_ready_reg;
  assign o_rx_byte  = rx_byte_reg;
  assign o_rx_valid = rx_valid_reg;
  assign o_busy     = busy_reg;
  assign o_sclk     = sclk_reg;
  assign o_mosi     = mosi_reg;
  assign o_ss       = ss_reg;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: drives five spi_master instances that share one clock and reset.
//   - Instances 0..3 run MODE 0..3, MSB first.
//   - Instance 4 runs MODE 0, LSB first.
// Each instance is wired to a behavioural SPI slave. The slave returns a chosen
// byte and reassembles what it saw on MOSI.
// A scoreboard queue holds one expected result per accepted byte. A monitor
// pops an entry on each o_rx_valid and checks:
//   - the received byte;
//   - the MOSI byte reassembled by the slave;
//   - the latency from acceptance.
module tb_spi_master;

  localparam int N      = 5;
  localparam int DIV    = 2;
  localparam int GAP    = 2;
  localparam int LAT    = 1 + 18 * DIV;
  localparam int SS_LOW = 18 * DIV;
  localparam int PERIOD = 2 + 18 * DIV + GAP;

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  typedef struct {
    int         inst;
    logic [7:0] exp_rx;
    logic [7:0] exp_tx;
    int         acc_cyc;
  } sb_t;

  logic                w_Clk = 1'b0;
  logic                i_Rst_n = 1'b0;
  logic [N-1:0]        tx_valid_v;
  logic [N-1:0][7:0]   tx_byte_v;
  logic [N-1:0]        tx_ready_v;
  logic [N-1:0][7:0]   rx_byte_v;
  logic [N-1:0]        rx_valid_v;
  logic [N-1:0]        busy_v;
  logic [N-1:0]        sclk_v;
  logic [N-1:0]        mosi_v;
  logic [N-1:0]        miso_v;
  logic [N-1:0]        ss_v;

  logic [7:0] slave_tx [N];
  logic [7:0] slave_rx [N];

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  sb_t sb_q[$];
  int  frames [N];
  int  edges [N];
  int  ss_len [N];
  int  last_fall [N];
  bit  rdy_in_frame [N];
  bit  chk_period = 1'b0;
  bit  skip_len = 1'b0;

  // DUT instances
  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    spi_master #(
      .MODE         ((gi < 4) ? gi : 0),
      .FRAME_FORMAT ((gi == 4) ? 1 : 0),
      .CLK_DIV      (DIV),
      .CS_GAP       (GAP)
    ) u_dut (
      .w_Clk      (w_Clk),
      .i_Rst_n    (i_Rst_n),
      .i_tx_valid (tx_valid_v[gi]),
      .i_tx_byte  (tx_byte_v[gi]),
      .o_tx_ready (tx_ready_v[gi]),
      .o_rx_byte  (rx_byte_v[gi]),
      .o_rx_valid (rx_valid_v[gi]),
      .o_busy     (busy_v[gi]),
      .o_sclk     (sclk_v[gi]),
      .o_mosi     (mosi_v[gi]),
      .i_miso     (miso_v[gi]),
      .o_ss       (ss_v[gi])
    );
  end

  function automatic logic cpol_of(input int k);
    return (k == 2) || (k == 3);
  endfunction

  function automatic logic cpha_of(input int k);
    return (k == 1) || (k == 3);
  endfunction

  // Bit position of the n-th bit on the wire for instance k.
  function automatic int pos(input int n, input int k);
    return (k == 4) ? n : 7 - n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever #5 w_Clk = ~w_Clk;

  initial forever begin
    @(posedge w_Clk);
    cyc = cyc + 1;
  end

  // Behavioural slave for every instance; reacts to SCLK/SS seen at negedge.
  initial begin
    logic s_prev_ss [N];
    logic s_prev_sclk [N];
    int   s_dcnt [N];
    int   s_scnt [N];
    for (int k = 0; k < N; k++) begin
      s_prev_ss[k]   = 1'b1;
      s_prev_sclk[k] = cpol_of(k);
      s_dcnt[k]      = 0;
      s_scnt[k]      = 0;
      miso_v[k]      = 1'b0;
      slave_rx[k]    = 8'h00;
    end
    forever begin
      @(negedge w_Clk);
      for (int k = 0; k < N; k++) begin
        if (ss_v[k] !== 1'b0) begin
          s_dcnt[k] = 0;
          s_scnt[k] = 0;
        end else begin
          if (s_prev_ss[k]) begin
            slave_rx[k] = 8'h00;
            if (!cpha_of(k)) begin
              miso_v[k] = slave_tx[k][pos(0, k)];
              s_dcnt[k] = 1;
            end
          end
          if (sclk_v[k] != s_prev_sclk[k]) begin
            if ((sclk_v[k] != cpol_of(k)) == !cpha_of(k)) begin
              if (s_scnt[k] < 8) slave_rx[k][pos(s_scnt[k], k)] = mosi_v[k];
              s_scnt[k]++;
            end else if (s_dcnt[k] < 8) begin
              miso_v[k] = slave_tx[k][pos(s_dcnt[k], k)];
              s_dcnt[k]++;
            end
          end
        end
        s_prev_ss[k]   = ss_v[k];
        s_prev_sclk[k] = sclk_v[k];
      end
    end
  end

  // Monitor: frame shape checks and scoreboard comparison on o_rx_valid.
  initial begin
    logic m_prev_ss [N];
    logic m_prev_sclk [N];
    sb_t  e;
    for (int k = 0; k < N; k++) begin
      m_prev_ss[k]   = 1'b1;
      m_prev_sclk[k] = cpol_of(k);
    end
    forever begin
      @(negedge w_Clk);
      for (int k = 0; k < N; k++) begin
        if (ss_v[k] === 1'b0) begin
          if (m_prev_ss[k]) begin
            frames[k]++;
            ss_len[k] = 0;
            edges[k] = 0;
            rdy_in_frame[k] = 1'b0;
            if (chk_period && last_fall[k] >= 0) chk("frame_period", cyc - last_fall[k], PERIOD);
            last_fall[k] = cyc;
          end
          ss_len[k]++;
          if (sclk_v[k] != m_prev_sclk[k]) edges[k]++;
          if (tx_ready_v[k]) rdy_in_frame[k] = 1'b1;
        end else if (m_prev_ss[k] === 1'b0 && !skip_len) begin
          chk("ss_low_cycles", ss_len[k], SS_LOW);
          chk("ready_during_frame", int'(rdy_in_frame[k]), 0);
          chk("sclk_idle_level", int'(sclk_v[k]), int'(cpol_of(k)));
        end
        if (rx_valid_v[k] === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("rx_valid_spurious", int'(rx_valid_v[k]), 0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_instance", k, e.inst);
            chk("rx_byte", int'(rx_byte_v[k]), int'(e.exp_rx));
            chk("mosi_byte", int'(slave_rx[k]), int'(e.exp_tx));
            chk("rx_latency", cyc - e.acc_cyc, LAT);
            $display("frame inst=%0d mosi=%02h rx=%02h latency=%0d",
                     k, slave_rx[k], rx_byte_v[k], cyc - e.acc_cyc);
          end
        end
        m_prev_ss[k]   = ss_v[k];
        m_prev_sclk[k] = sclk_v[k];
      end
    end
  end

  // Offer one byte and wait until it is accepted. Pushes the expectation at
  // the negedge right after the accepting clock edge.
  task automatic send(input int k, input logic [7:0] b, input logic [7:0] exp_rx,
                      input logic [7:0] exp_mosi);
    int t;
    t = 0;
    @(negedge w_Clk);
    tx_valid_v[k] = 1'b1;
    tx_byte_v[k]  = b;
    while (!tx_ready_v[k] && t < 500) begin
      @(negedge w_Clk);
      t++;
    end
    if (!tx_ready_v[k]) begin
      chk("accept_timeout", int'(tx_ready_v[k]), 1);
      tx_valid_v[k] = 1'b0;
    end else begin
      @(negedge w_Clk);
      tx_valid_v[k] = 1'b0;
      sb_q.push_back('{k, exp_rx, exp_mosi, cyc});
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy_v != '0) && t < 3000) begin
      @(negedge w_Clk);
      t++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Watchdog
  initial begin
    repeat (50000) @(posedge w_Clk);
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [10];
    logic [13:0] got_rst;
    logic [13:0] exp_rst;
    int          f0;
    int          t;
    logic [7:0]  b2b [3];

    vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[2] = '{2, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[3] = '{3, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[4] = '{4, 8'h01, 8'h80, 8'h80, 8'h01};
    vecs[5] = '{0, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{3, 8'hC3, 8'h5A, 8'h5A, 8'hC3};
    vecs[7] = '{4, 8'hB2, 8'h4D, 8'h4D, 8'hB2};
    vecs[8] = '{1, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[9] = '{2, 8'h7E, 8'h81, 8'h81, 8'h7E};

    for (int k = 0; k < N; k++) begin
      tx_valid_v[k] = 1'b0;
      tx_byte_v[k]  = 8'h00;
      slave_tx[k]   = 8'h00;
      frames[k]     = 0;
      edges[k]      = 0;
      ss_len[k]     = 0;
      last_fall[k]  = -1;
      rdy_in_frame[k] = 1'b0;
    end

    // Reset values for every instance
    repeat (3) @(negedge w_Clk);
    for (int k = 0; k < N; k++) begin
      got_rst = {ss_v[k], sclk_v[k], mosi_v[k], tx_ready_v[k], rx_valid_v[k], busy_v[k], rx_byte_v[k]};
      exp_rst = {1'b1, cpol_of(k), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      chk("reset_outputs", int'(got_rst), int'(exp_rst));
    end

    // o_tx_ready rises CS_GAP clock edges after release
    i_Rst_n = 1'b1;
    for (int i = 1; i < GAP; i++) begin
      @(negedge w_Clk);
      chk("ready_before_gap_end", int'(tx_ready_v[0]), 0);
    end
    @(negedge w_Clk);
    chk("ready_after_gap", int'(tx_ready_v[0]), 1);

    // Table-driven single frames across all modes and framings
    for (int i = 0; i < 10; i++) begin
      slave_tx[vecs[i].inst] = vecs[i].resp;
      send(vecs[i].inst, vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_mosi);
      wait_drain();
    end

    // Back-to-back frames with i_tx_valid held high
    b2b[0] = 8'h11;
    b2b[1] = 8'h22;
    b2b[2] = 8'h33;
    slave_tx[0] = 8'hC6;
    f0 = frames[0];
    last_fall[0] = -1;
    chk_period = 1'b1;
    @(negedge w_Clk);
    tx_valid_v[0] = 1'b1;
    tx_byte_v[0]  = b2b[0];
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (!tx_ready_v[0] && t < 500) begin
        @(negedge w_Clk);
        t++;
      end
      chk("b2b_ready", int'(tx_ready_v[0]), 1);
      @(negedge w_Clk);
      sb_q.push_back('{0, 8'hC6, b2b[i], cyc});
      if (i < 2) tx_byte_v[0] = b2b[i + 1];
    end
    tx_valid_v[0] = 1'b0;
    wait_drain();
    chk_period = 1'b0;
    chk("b2b_frame_count", frames[0] - f0, 3);

    // A byte offered while busy is ignored
    slave_tx[1] = 8'h3C;
    f0 = frames[1];
    send(1, 8'h5A, 8'h3C, 8'h5A);
    repeat (5) @(negedge w_Clk);
    chk("busy_mid_frame", int'(busy_v[1]), 1);
    tx_valid_v[1] = 1'b1;
    tx_byte_v[1]  = 8'hFF;
    @(negedge w_Clk);
    tx_valid_v[1] = 1'b0;
    wait_drain();
    repeat (60) @(negedge w_Clk);
    chk("ignored_byte_frames", frames[1] - f0, 1);
    send(1, 8'h96, 8'h3C, 8'h96);
    wait_drain();

    // Reset after SCLK edge 7 of a MODE 2 frame
    slave_tx[2] = 8'h3C;
    edges[2] = 0;
    send(2, 8'hA5, 8'h3C, 8'hA5);
    t = 0;
    while (edges[2] < 7 && t < 500) begin
      @(negedge w_Clk);
      t++;
    end
    chk("edge7_reached", edges[2], 7);
    skip_len = 1'b1;
    i_Rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_ss", int'(ss_v[2]), 1);
    chk("midrst_sclk", int'(sclk_v[2]), int'(cpol_of(2)));
    repeat (3) @(negedge w_Clk);
    i_Rst_n = 1'b1;
    for (int i = 1; i < GAP; i++) begin
      @(negedge w_Clk);
      chk("midrst_ready_early", int'(tx_ready_v[2]), 0);
    end
    @(negedge w_Clk);
    chk("midrst_ready_after_gap", int'(tx_ready_v[2]), 1);
    skip_len = 1'b0;
    send(2, 8'h69, 8'h3C, 8'h69);
    wait_drain();

    repeat (5) @(negedge w_Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
